// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one data-memory port between the instruction and data caches.
// Round-robin on conflict, one-cycle release gap after every grant, sticky timeout flag.
//
// state   | meaning
// IDLE    | no grant; arbitrate between asserted enables
// GRANT   | granted port drives the memory request, waits for mem_ack_i
// RELEASE | one-cycle gap, no grant, acks suppressed
module mem_port_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         m0_enable_i,
   input  logic         m0_write_i,
   input  logic [31:0]  m0_addr_i,
   input  logic [255:0] m0_data_i,
   output logic [255:0] m0_data_o,
   output logic         m0_ack_o,
   input  logic         m1_enable_i,
   input  logic         m1_write_i,
   input  logic [31:0]  m1_addr_i,
   input  logic [255:0] m1_data_i,
   output logic [255:0] m1_data_o,
   output logic         m1_ack_o,
   output logic         mem_enable_o,
   output logic         mem_write_o,
   output logic [31:0]  mem_addr_o,
   output logic [255:0] mem_data_o,
   input  logic [255:0] mem_data_i,
   input  logic         mem_ack_i,
   output logic [1:0]   gnt_o,
   output logic         err_o
);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic [1:0]  gnt_q, gnt_d;
   logic        last_q, last_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;

   logic sel1;
   logic in_grant;
   logic granted_en;

   assign sel1       = gnt_q[1];
   assign in_grant   = (state_q == GRANT);
   assign granted_en = sel1 ? m1_enable_i : m0_enable_i;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            if (m0_enable_i && m1_enable_i) begin
               // last_q == 1 means port 1 was served last, so port 0 goes next
               gnt_d   = last_q ? 2'b01 : 2'b10;
               state_d = GRANT;
            end else if (m0_enable_i) begin
               gnt_d   = 2'b01;
               state_d = GRANT;
            end else if (m1_enable_i) begin
               gnt_d   = 2'b10;
               state_d = GRANT;
            end
         end
         GRANT: begin
            cnt_d = (cnt_q == TMO) ? cnt_q : cnt_q + 8'd1;
            if (cnt_d == TMO) err_d = 1'b1;
            if (mem_ack_i) begin
               state_d = RELEASE;
               gnt_d   = 2'b00;
               last_d  = sel1;
            end else if (!granted_en) begin
               state_d = RELEASE;
               gnt_d   = 2'b00;
            end
         end
         RELEASE: begin
            state_d = IDLE;
            gnt_d   = 2'b00;
            cnt_d   = 8'd0;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 2'b00;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         gnt_q   <= 2'b00;
         last_q  <= 1'b1;
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Request path is combinational from the granted port so latency stays at one cycle.
   assign mem_enable_o = in_grant & granted_en;
   assign mem_write_o  = sel1 ? m1_write_i : m0_write_i;
   assign mem_addr_o   = sel1 ? m1_addr_i  : m0_addr_i;
   assign mem_data_o   = sel1 ? m1_data_i  : m0_data_i;

   assign m0_data_o = mem_data_i;
   assign m1_data_o = mem_data_i;
   assign m0_ack_o  = in_grant & gnt_q[0] & mem_ack_i;
   assign m1_ack_o  = in_grant & gnt_q[1] & mem_ack_i;

   assign gnt_o = gnt_q;
   assign err_o = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: round-robin, release gap, abort, timeout and async reset.
module tb_mem_port_arbiter;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         m0_enable_i, m0_write_i;
   logic [31:0]  m0_addr_i;
   logic [255:0] m0_data_i, m0_data_o;
   logic         m0_ack_o;
   logic         m1_enable_i, m1_write_i;
   logic [31:0]  m1_addr_i;
   logic [255:0] m1_data_i, m1_data_o;
   logic         m1_ack_o;
   logic         mem_enable_o, mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o, mem_data_i;
   logic         mem_ack_i;
   logic [1:0]   gnt_o;
   logic         err_o;

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter #(.TIMEOUT(20)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
      .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
      .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
      .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .gnt_o(gnt_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Pulse ack in GRANT, then confirm the release cycle ignores a still-high ack.
   task automatic ack_pulse(input string tag, input logic exp0, input logic exp1);
      mem_ack_i = 1'b1;
      #1;
      chk({tag, "_ack0"}, 256'(m0_ack_o), 256'(exp0));
      chk({tag, "_ack1"}, 256'(m1_ack_o), 256'(exp1));
      tick();
      chk({tag, "_rel_gnt"}, 256'(gnt_o), 256'(2'b00));
      chk({tag, "_rel_men"}, 256'(mem_enable_o), 256'(1'b0));
      chk({tag, "_rel_noack"}, 256'({m1_ack_o, m0_ack_o}), 256'(2'b00));
      mem_ack_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b0;
      m0_enable_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = 32'h0; m0_data_i = {8{32'h0000_C0DE}};
      m1_enable_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = 32'h0; m1_data_i = {8{32'h1111_BEEF}};
      mem_data_i = {8{32'hA5A5_5A5A}};
      mem_ack_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_gnt", 256'(gnt_o), 256'(2'b00));
      chk("rst_err", 256'(err_o), 256'(1'b0));
      chk("rst_men", 256'(mem_enable_o), 256'(1'b0));
      chk("rst_acks", 256'({m1_ack_o, m0_ack_o}), 256'(2'b00));
      chk("data_route0", m0_data_o, {8{32'hA5A5_5A5A}});
      chk("data_route1", m1_data_o, {8{32'hA5A5_5A5A}});
      mem_ack_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      tick();

      // simultaneous requests after reset: port 0 first, then alternate
      m0_enable_i = 1'b1; m0_addr_i = 32'h0000_0100;
      m1_enable_i = 1'b1; m1_addr_i = 32'h0000_0200;
      #1;
      chk("conf_idle_men", 256'(mem_enable_o), 256'(1'b0));
      tick();
      chk("conf1_gnt", 256'(gnt_o), 256'(2'b01));
      chk("conf1_addr", 256'(mem_addr_o), 256'(32'h100));
      chk("conf1_wdata", mem_data_o, {8{32'h0000_C0DE}});
      ack_pulse("conf1", 1'b1, 1'b0);
      tick();
      chk("conf_gap_idle", 256'(gnt_o), 256'(2'b00));
      tick();
      chk("conf2_gnt", 256'(gnt_o), 256'(2'b10));
      chk("conf2_addr", 256'(mem_addr_o), 256'(32'h200));
      ack_pulse("conf2", 1'b0, 1'b1);
      tick();
      tick();
      chk("conf3_gnt", 256'(gnt_o), 256'(2'b01));
      ack_pulse("conf3", 1'b1, 1'b0);
      m0_enable_i = 1'b0; m1_enable_i = 1'b0;
      tick();

      // lone m1 read, ack after 10 cycles
      m1_enable_i = 1'b1; m1_addr_i = 32'h0000_0400; m1_write_i = 1'b0;
      tick();
      chk("rd_gnt", 256'(gnt_o), 256'(2'b10));
      chk("rd_men", 256'(mem_enable_o), 256'(1'b1));
      chk("rd_addr", 256'(mem_addr_o), 256'(32'h400));
      chk("rd_wr", 256'(mem_write_o), 256'(1'b0));
      chk("rd_wdata", mem_data_o, {8{32'h1111_BEEF}});
      repeat (9) tick();
      chk("rd_wait_gnt", 256'(gnt_o), 256'(2'b10));
      chk("rd_wait_noack", 256'({m1_ack_o, m0_ack_o}), 256'(2'b00));
      ack_pulse("rd", 1'b0, 1'b1);
      m1_enable_i = 1'b0;
      tick();
      chk("rd_idle", 256'(gnt_o), 256'(2'b00));

      // dcache write-back then refill with enable held high
      m1_enable_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h0000_0800;
      tick();
      chk("wb_wr", 256'(mem_write_o), 256'(1'b1));
      chk("wb_addr", 256'(mem_addr_o), 256'(32'h800));
      ack_pulse("wb", 1'b0, 1'b1);
      m1_write_i = 1'b0; m1_addr_i = 32'h0000_0C00;
      tick();
      chk("wb_gap_men", 256'(mem_enable_o), 256'(1'b0));
      tick();
      chk("rf_gnt", 256'(gnt_o), 256'(2'b10));
      chk("rf_men", 256'(mem_enable_o), 256'(1'b1));
      chk("rf_wr", 256'(mem_write_o), 256'(1'b0));
      chk("rf_addr", 256'(mem_addr_o), 256'(32'hC00));
      ack_pulse("rf", 1'b0, 1'b1);
      m1_enable_i = 1'b0;
      tick();

      // abort: last grant stays on port 1, so port 0 still wins the next conflict
      m0_enable_i = 1'b1; m0_addr_i = 32'h0000_0040;
      tick();
      chk("ab_gnt", 256'(gnt_o), 256'(2'b01));
      repeat (3) tick();
      m0_enable_i = 1'b0;
      #1;
      chk("ab_men_drop", 256'(mem_enable_o), 256'(1'b0));
      tick();
      chk("ab_rel_gnt", 256'(gnt_o), 256'(2'b00));
      chk("ab_noack", 256'({m1_ack_o, m0_ack_o}), 256'(2'b00));
      tick();
      m0_enable_i = 1'b1; m1_enable_i = 1'b1;
      tick();
      chk("ab_conf_gnt", 256'(gnt_o), 256'(2'b01));
      ack_pulse("ab_conf", 1'b1, 1'b0);
      m0_enable_i = 1'b0; m1_enable_i = 1'b0;
      tick();

      // timeout after 20 GRANT cycles, grant kept, err sticky
      m0_enable_i = 1'b1;
      tick();
      chk("to_gnt", 256'(gnt_o), 256'(2'b01));
      repeat (19) tick();
      chk("to_err_19", 256'(err_o), 256'(1'b0));
      tick();
      chk("to_err_20", 256'(err_o), 256'(1'b1));
      chk("to_gnt_kept", 256'(gnt_o), 256'(2'b01));
      chk("to_men_kept", 256'(mem_enable_o), 256'(1'b1));
      repeat (10) tick();
      chk("to_err_hold", 256'(err_o), 256'(1'b1));
      ack_pulse("to", 1'b1, 1'b0);
      m0_enable_i = 1'b0;
      tick();
      chk("to_err_sticky", 256'(err_o), 256'(1'b1));

      // reset mid-GRANT
      m1_enable_i = 1'b1; m1_addr_i = 32'h0000_0400;
      tick();
      chk("mr_gnt", 256'(gnt_o), 256'(2'b10));
      #1;
      rst_i = 1'b0;
      mem_ack_i = 1'b1;
      #1;
      chk("mr_men", 256'(mem_enable_o), 256'(1'b0));
      chk("mr_gnt0", 256'(gnt_o), 256'(2'b00));
      chk("mr_err", 256'(err_o), 256'(1'b0));
      chk("mr_acks", 256'({m1_ack_o, m0_ack_o}), 256'(2'b00));
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      chk("mr_post_acks", 256'({m1_ack_o, m0_ack_o}), 256'(2'b00));
      mem_ack_i = 1'b0;
      tick();
      chk("mr_regrant", 256'(gnt_o), 256'(2'b10));
      m1_enable_i = 1'b0;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of cycles a grant may wait for mem_ack_i before err_o is set.
REQ-002 SHALL have port clk_i, input, 1, the clock.
REQ-003 SHALL have port rst_i, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have ports m0_enable_i / m0_write_i, input, 1 each: port-0 (instruction cache) request and write flag.
REQ-005 SHALL have ports m0_addr_i (input, 32) and m0_data_i (input, 256): port-0 line address and write data.
REQ-006 SHALL have ports m0_data_o (output, 256) and m0_ack_o (output, 1): port-0 read data and acknowledge.
REQ-007 SHALL have ports m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o: port-1 (data cache) equivalents, same widths and directions.
REQ-008 SHALL have ports mem_enable_o, mem_write_o (output, 1), mem_addr_o (output, 32) and mem_data_o (output, 256): the shared data-memory request.
REQ-009 SHALL have ports mem_data_i (input, 256) and mem_ack_i (input, 1): the shared data-memory response.
REQ-010 SHALL have port gnt_o, output, 2: one-hot current grant, {port1, port0}.
REQ-011 SHALL have port err_o, output, 1: sticky timeout flag.

Function
REQ-012 SHALL implement three states: IDLE, GRANT, RELEASE.
REQ-013 SHALL, in IDLE with no enable asserted, stay in IDLE with gnt_o=00.
REQ-014 SHALL, in IDLE with exactly one mX_enable_i high, enter GRANT for that port at the next edge.
REQ-015 SHALL, in IDLE with both enables high, grant the port that did not hold the last grant (round-robin); after reset the last-grant register points to port 1, so port 0 wins first.
REQ-016 SHALL, in GRANT, drive mem_enable_o, mem_write_o, mem_addr_o and mem_data_o combinationally from the granted port only.
REQ-017 SHALL drive mem_enable_o=0 in IDLE and RELEASE; mem_write_o, mem_addr_o and mem_data_o are don't-care when mem_enable_o=0.
REQ-018 SHALL route mem_data_i to both m0_data_o and m1_data_o at all times.
REQ-019 SHALL assert mX_ack_o = mem_ack_i only for the granted port in GRANT; the non-granted ack SHALL be 0.
REQ-020 SHALL, on mem_ack_i=1 in GRANT, move to RELEASE and update the last-grant register to the granted port.
REQ-021 SHALL, if the granted port drops enable in GRANT before ack (abort), move to RELEASE without updating the last-grant register.
REQ-022 SHALL hold RELEASE for exactly one cycle, then return to IDLE; gnt_o=00 in RELEASE.
REQ-023 SHALL keep this one-cycle gap even when the same port holds enable continuously, e.g. dcache write-back followed by refill; that port re-arbitrates in IDLE.
REQ-024 SHALL ignore mem_ack_i in IDLE and RELEASE; no ack is forwarded to either port.
REQ-025 SHALL count cycles spent in GRANT with an 8-bit wait counter, cleared on every entry to GRANT.
REQ-026 SHALL set err_o when the wait counter reaches TIMEOUT, keep the grant, and hold err_o until reset.
REQ-027 SHALL keep the wait counter saturating at TIMEOUT and never wrap.
REQ-028 SHALL give a non-granted port no ack until its grant arrives; minimum latency from enable in IDLE to mem_enable_o is 1 cycle.

Reset
REQ-029 SHALL, while rst_i=0, force: state=IDLE, gnt_o=00, err_o=0, wait counter=0, last-grant=port 1, both acks=0, mem_enable_o=0.
REQ-030 SHALL, on reset asserted mid-GRANT, drop mem_enable_o immediately (asynchronously), and an ack arriving after reset SHALL be ignored.

Verification
REQ-031 SHALL cover a lone m1 read: m1_enable_i=1, addr 0x00000400, ack after 10 cycles -> gnt_o=10, mem_addr_o=0x400, m1_ack_o pulses once, m0_ack_o=0, then 1 RELEASE cycle.
REQ-032 SHALL cover simultaneous requests after reset: both enables high -> port 0 served first, port 1 granted in the IDLE that follows RELEASE; a repeated conflict then alternates.
REQ-033 SHALL cover dcache write-back then refill with m1_enable_i held high: first m1_write_i=1 ack -> RELEASE (mem_enable_o=0 for 1 cycle) -> regrant with m1_write_i=0 and the new address.
REQ-034 SHALL cover an abort: m0 granted, m0_enable_i dropped after 3 cycles -> RELEASE, no ack, and port 0 keeps priority on the next conflict.
REQ-035 SHALL cover timeout with TIMEOUT=20: no ack -> err_o=1 after 20 GRANT cycles, grant kept; a later ack completes normally and err_o stays 1.
REQ-036 SHALL cover reset mid-GRANT -> outputs take their reset values immediately, and an ack during reset produces no ack output.
